// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped, partially tagged BTB with 2-bit
// saturating direction counters, mispredict detection and saturating stats.
module branch_predictor #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_npc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_is_jump,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            flush_all,
  output logic [CNT_W-1:0] stat_lookups,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [CNT_W-1:0] lookups_q, lookups_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] mispreds_q, mispreds_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;

  // Combinational lookup with the fetch PC; independent of if_valid.
  always_comb begin
    lk_idx     = if_pc[IDX_W+1:2];
    lk_tag     = if_pc[IDX_W+2 +: TAG_W];
    lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken = lk_hit && ctr_q[lk_idx][1];
    pred_npc   = pred_taken ? target_q[lk_idx] : if_pc + XLEN'(4);
  end

  // Resolve-stage mispredict check and correct next PC.
  always_comb begin
    mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
  end

  // Next-state of the table: flush wins over a same-cycle update.
  always_comb begin
    up_idx   = upd_pc[IDX_W+1:2];
    up_tag   = upd_pc[IDX_W+2 +: TAG_W];
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (flush_all) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_is_jump) begin
          ctr_d[up_idx]    = 2'b11;
          target_d[up_idx] = upd_target;
        end else if (upd_taken) begin
          if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
          target_d[up_idx] = upd_target;
        end else begin
          if (ctr_q[up_idx] != 2'b00) ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        // Allocate over whatever occupies the slot; jumps start strongly taken.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        ctr_d[up_idx]    = upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  // Saturating statistics counters.
  always_comb begin
    lookups_d  = lookups_q;
    hits_d     = hits_q;
    mispreds_d = mispreds_q;
    if (if_valid && (lookups_q != '1)) lookups_d = lookups_q + CNT_W'(1);
    if (if_valid && lk_hit && (hits_q != '1)) hits_d = hits_q + CNT_W'(1);
    if (mispredict && (mispreds_q != '1)) mispreds_d = mispreds_q + CNT_W'(1);
  end

  // Valid bits, counters and statistics carry reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      ctr_q      <= '{default: 2'b01};
      lookups_q  <= '0;
      hits_q     <= '0;
      mispreds_q <= '0;
    end else begin
      valid_q    <= valid_d;
      ctr_q      <= ctr_d;
      lookups_q  <= lookups_d;
      hits_q     <= hits_d;
      mispreds_q <= mispreds_d;
    end
  end

  // Tags and targets are masked by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign stat_lookups     = lookups_q;
  assign stat_hits        = hits_q;
  assign stat_mispredicts = mispreds_q;

endmodule
